// File: rtl/gf_exp_log_table.sv
// GF(2^M) exp/log table builder: steps alpha = x through the field after a start pulse,
// then answers one exp and one log lookup per cycle.
module gf_exp_log_table #(
    parameter int M = 8,
    parameter int N = (1 << M) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] poly,
    output logic         busy,
    output logic         done,
    output logic         ready,
    output logic         poly_err,
    output logic         prim,
    output logic [M-1:0] order,
    input  logic         exp_rd,
    input  logic [M-1:0] exp_addr,
    output logic         exp_vld,
    output logic [M-1:0] exp_data,
    input  logic         log_rd,
    input  logic [M-1:0] log_addr,
    output logic         log_vld,
    output logic [M-1:0] log_data,
    output logic         log_hit
);

    localparam int SIZE = 1 << M;
    localparam logic [M-1:0] LAST = M'(N - 1);
    localparam logic [M-1:0] ONE  = M'(1);

    typedef enum logic [1:0] {IDLE, BUILD, READY} state_t;

    state_t            state_q, state_d;
    logic [M-1:0]      poly_q, poly_d;
    logic [M-1:0]      cur_q, cur_d;
    logic [M-1:0]      idx_q, idx_d;
    logic [M-1:0]      order_q, order_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              poly_err_q, poly_err_d;
    logic              prim_q, prim_d;
    logic [SIZE-1:0]   lvalid_q, lvalid_d;
    logic              exp_vld_q, exp_vld_d;
    logic [M-1:0]      exp_data_q, exp_data_d;
    logic              log_vld_q, log_vld_d;
    logic [M-1:0]      log_data_q, log_data_d;
    logic              log_hit_q, log_hit_d;

    logic [M-1:0]      exp_mem [SIZE];
    logic [M-1:0]      log_mem [SIZE];
    logic              tbl_we;
    logic              log_we;
    logic [M-1:0]      next_cur;
    logic              rd_ok;

    always_comb begin
        state_d    = state_q;
        poly_d     = poly_q;
        cur_d      = cur_q;
        idx_d      = idx_q;
        order_d    = order_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ready_d    = ready_q;
        poly_err_d = poly_err_q;
        prim_d     = prim_q;
        lvalid_d   = lvalid_q;
        tbl_we     = 1'b0;
        log_we     = 1'b0;
        next_cur   = {cur_q[M-2:0], 1'b0} ^ (cur_q[M-1] ? poly_q : '0);

        if (start) begin
            if (!poly[0]) begin
                poly_err_d = 1'b1;
                ready_d    = 1'b0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end else begin
                poly_d     = poly;
                cur_d      = ONE;
                idx_d      = '0;
                lvalid_d   = '0;
                ready_d    = 1'b0;
                poly_err_d = 1'b0;
                order_d    = '0;
                prim_d     = 1'b0;
                busy_d     = 1'b1;
                state_d    = BUILD;
            end
        end else if (state_q == BUILD) begin
            tbl_we = 1'b1;
            // First writer wins, so a log entry always holds the smallest exponent.
            if (!lvalid_q[cur_q]) begin
                log_we           = 1'b1;
                lvalid_d[cur_q]  = 1'b1;
            end
            cur_d = next_cur;
            idx_d = idx_q + ONE;
            if (idx_q != '0 && cur_q == ONE && order_q == '0)
                order_d = idx_q;
            if (idx_q == LAST) begin
                // alpha^N is next_cur; order N means the full field was traversed.
                if (next_cur == ONE && order_d == '0)
                    order_d = '1;
                prim_d  = (order_d == '1);
                busy_d  = 1'b0;
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = READY;
            end
        end

        // A coincident start revokes ready before the lookup is answered.
        rd_ok      = ready_q && !start;
        exp_vld_d  = exp_rd;
        log_vld_d  = log_rd;
        exp_data_d = '0;
        log_data_d = '0;
        log_hit_d  = 1'b0;
        if (exp_rd && rd_ok)
            exp_data_d = (exp_addr == '1) ? ONE : exp_mem[exp_addr];
        if (log_rd && rd_ok && log_addr != '0 && lvalid_q[log_addr]) begin
            log_data_d = log_mem[log_addr];
            log_hit_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            poly_q     <= '0;
            cur_q      <= '0;
            idx_q      <= '0;
            order_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            poly_err_q <= 1'b0;
            prim_q     <= 1'b0;
            lvalid_q   <= '0;
            exp_vld_q  <= 1'b0;
            exp_data_q <= '0;
            log_vld_q  <= 1'b0;
            log_data_q <= '0;
            log_hit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            poly_q     <= poly_d;
            cur_q      <= cur_d;
            idx_q      <= idx_d;
            order_q    <= order_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            poly_err_q <= poly_err_d;
            prim_q     <= prim_d;
            lvalid_q   <= lvalid_d;
            exp_vld_q  <= exp_vld_d;
            exp_data_q <= exp_data_d;
            log_vld_q  <= log_vld_d;
            log_data_q <= log_data_d;
            log_hit_q  <= log_hit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we)
            exp_mem[idx_q] <= cur_q;
        if (log_we)
            log_mem[cur_q] <= idx_q;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ready    = ready_q;
    assign poly_err = poly_err_q;
    assign prim     = prim_q;
    assign order    = order_q;
    assign exp_vld  = exp_vld_q;
    assign exp_data = exp_data_q;
    assign log_vld  = log_vld_q;
    assign log_data = log_data_q;
    assign log_hit  = log_hit_q;

endmodule

// File: tb/tb_gf_exp_log_table.sv
// Directed bench for gf_exp_log_table at M=8: builds with 0x1D / 0x1B, lookups, restart,
// bad polynomial and mid-build reset, checked against hand-computed GF(256) values.
module tb_gf_exp_log_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] poly;
    logic       busy, done, ready, poly_err, prim;
    logic [7:0] order;
    logic       exp_rd, exp_vld;
    logic [7:0] exp_addr, exp_data;
    logic       log_rd, log_vld, log_hit;
    logic [7:0] log_addr, log_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gf_exp_log_table #(.M(8)) dut (
        .clk(clk), .rst(rst), .start(start), .poly(poly),
        .busy(busy), .done(done), .ready(ready), .poly_err(poly_err),
        .prim(prim), .order(order),
        .exp_rd(exp_rd), .exp_addr(exp_addr), .exp_vld(exp_vld), .exp_data(exp_data),
        .log_rd(log_rd), .log_addr(log_addr), .log_vld(log_vld), .log_data(log_data),
        .log_hit(log_hit)
    );

    // All tasks are entered and left at a falling edge.
    task automatic lookup(input logic [7:0] ea, input logic [7:0] la);
        exp_rd = 1'b1; exp_addr = ea;
        log_rd = 1'b1; log_addr = la;
        @(negedge clk);
        exp_rd = 1'b0; log_rd = 1'b0;
    endtask

    // Returns the number of falling edges from the start edge until done is seen (400 = timeout).
    task automatic build(input logic [7:0] p, output int cycles);
        start = 1'b1; poly = p;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; poly = '0;
        exp_rd = 1'b0; exp_addr = '0; log_rd = 1'b0; log_addr = '0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, ready, poly_err, prim} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, ready, poly_err, prim});
        end
        vectors++;
        if (order !== 8'h00) begin
            miscompares++; $display("FAIL reset_order: got %h expected 00", order);
        end
        vectors++;
        if ({exp_vld, exp_data, log_vld, log_data, log_hit} !== 19'b0) begin
            miscompares++;
            $display("FAIL reset_lookup: got %b expected all zero", {exp_vld, exp_data, log_vld, log_data, log_hit});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_primitive();
        int cyc;
        build(8'h1D, cyc);
        vectors++;
        if (cyc !== 256) begin
            miscompares++; $display("FAIL prim_done_latency: got %0d expected 256", cyc);
        end
        vectors++;
        if ({prim, ready, busy} !== 3'b110) begin
            miscompares++; $display("FAIL prim_flags: got prim/ready/busy=%b expected 110", {prim, ready, busy});
        end
        vectors++;
        if (order !== 8'd255) begin
            miscompares++; $display("FAIL prim_order: got %0d expected 255", order);
        end
        // Issued in the done cycle: must see the finished table.
        lookup(8'd254, 8'h8E);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL prim_done_pulse: got %b expected 0", done);
        end
        vectors++;
        if (exp_vld !== 1'b1 || exp_data !== 8'h8E) begin
            miscompares++; $display("FAIL prim_exp254: got vld=%b data=%h expected vld=1 data=8e", exp_vld, exp_data);
        end
        vectors++;
        if (log_vld !== 1'b1 || log_hit !== 1'b1 || log_data !== 8'd254) begin
            miscompares++; $display("FAIL prim_log8e: got hit=%b data=%0d expected hit=1 data=254", log_hit, log_data);
        end
        lookup(8'd8, 8'h1D);
        vectors++;
        if (exp_data !== 8'h1D) begin
            miscompares++; $display("FAIL prim_exp8: got %h expected 1d", exp_data);
        end
        vectors++;
        if (log_hit !== 1'b1 || log_data !== 8'd8) begin
            miscompares++; $display("FAIL prim_log1d: got hit=%b data=%0d expected hit=1 data=8", log_hit, log_data);
        end
        lookup(8'd0, 8'h02);
        vectors++;
        if (exp_data !== 8'h01 || log_hit !== 1'b1 || log_data !== 8'd1) begin
            miscompares++;
            $display("FAIL prim_exp0_log02: got exp=%h hit=%b log=%0d expected exp=01 hit=1 log=1", exp_data, log_hit, log_data);
        end
    endtask

    task automatic test_nonprimitive();
        int cyc;
        build(8'h1B, cyc);
        vectors++;
        if (cyc !== 256) begin
            miscompares++; $display("FAIL nonprim_done_latency: got %0d expected 256", cyc);
        end
        vectors++;
        if (prim !== 1'b0 || order !== 8'd51) begin
            miscompares++; $display("FAIL nonprim_order: got prim=%b order=%0d expected prim=0 order=51", prim, order);
        end
        lookup(8'd8, 8'h1B);
        vectors++;
        if (exp_data !== 8'h1B || log_hit !== 1'b1 || log_data !== 8'd8) begin
            miscompares++;
            $display("FAIL nonprim_8: got exp=%h hit=%b log=%0d expected exp=1b hit=1 log=8", exp_data, log_hit, log_data);
        end
        lookup(8'd51, 8'h03);
        vectors++;
        if (exp_data !== 8'h01) begin
            miscompares++; $display("FAIL nonprim_exp51: got %h expected 01", exp_data);
        end
        vectors++;
        if (log_vld !== 1'b1 || log_hit !== 1'b0 || log_data !== 8'h00) begin
            miscompares++;
            $display("FAIL nonprim_log03: got vld=%b hit=%b data=%h expected vld=1 hit=0 data=00", log_vld, log_hit, log_data);
        end
        lookup(8'd254, 8'h8D);
        vectors++;
        if (exp_data !== 8'h8D || log_hit !== 1'b1 || log_data !== 8'd50) begin
            miscompares++;
            $display("FAIL nonprim_254: got exp=%h hit=%b log=%0d expected exp=8d hit=1 log=50", exp_data, log_hit, log_data);
        end
    endtask

    task automatic test_edges();
        int cyc;
        build(8'h1D, cyc);
        vectors++;
        if (cyc !== 256) begin
            miscompares++; $display("FAIL edge_done_latency: got %0d expected 256", cyc);
        end
        lookup(8'd255, 8'h00);
        vectors++;
        if (exp_data !== 8'h01) begin
            miscompares++; $display("FAIL edge_exp255: got %h expected 01", exp_data);
        end
        vectors++;
        if (log_vld !== 1'b1 || log_hit !== 1'b0 || log_data !== 8'h00) begin
            miscompares++;
            $display("FAIL edge_log0: got vld=%b hit=%b data=%h expected vld=1 hit=0 data=00", log_vld, log_hit, log_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tbl [10];
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                exp_rd = 1'b1; exp_addr = 8'(i);
                log_rd = 1'b1; log_addr = tbl[i];
            end else begin
                exp_rd = 1'b0; log_rd = 1'b0;
            end
            @(negedge clk);
            vectors++;
            if (i < 10) begin
                if (exp_vld !== 1'b1 || exp_data !== tbl[i] || log_vld !== 1'b1 ||
                    log_hit !== 1'b1 || log_data !== 8'(i)) begin
                    miscompares++;
                    $display("FAIL b2b_%0d: got exp=%b/%h log=%b/%b/%0d expected exp=1/%h log=1/1/%0d",
                             i, exp_vld, exp_data, log_vld, log_hit, log_data, tbl[i], i);
                end
            end else if (exp_vld !== 1'b0 || log_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_idle: got exp_vld=%b log_vld=%b expected 0 0", exp_vld, log_vld);
            end
        end
    endtask

    task automatic test_bad_poly();
        int cyc;
        int dones;
        start = 1'b1; poly = 8'h1C;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (poly_err !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_flags: got err=%b busy=%b ready=%b expected 1 0 0", poly_err, busy, ready);
        end
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones !== 0 || poly_err !== 1'b1) begin
            miscompares++; $display("FAIL bad_no_done: got dones=%0d err=%b expected 0 1", dones, poly_err);
        end
        build(8'h1D, cyc);
        vectors++;
        if (cyc !== 256 || poly_err !== 1'b0 || prim !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_recover: got cyc=%0d err=%b prim=%b expected 256 0 1", cyc, poly_err, prim);
        end
    endtask

    task automatic test_restart();
        int cyc;
        int dones;
        // Start coincides with a lookup while ready: lookup must return zeros.
        start = 1'b1; poly = 8'h1B;
        exp_rd = 1'b1; exp_addr = 8'd1; log_rd = 1'b1; log_addr = 8'h02;
        @(negedge clk);
        start = 1'b0; exp_rd = 1'b0; log_rd = 1'b0;
        vectors++;
        if (exp_vld !== 1'b1 || exp_data !== 8'h00 || log_hit !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_start_lookup: got vld=%b exp=%h hit=%b busy=%b ready=%b expected 1 00 0 1 0",
                     exp_vld, exp_data, log_hit, busy, ready);
        end
        dones = 0;
        for (int i = 1; i < 100; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        build(8'h1D, cyc);
        vectors++;
        if (cyc !== 256 || dones !== 0) begin
            miscompares++; $display("FAIL restart_latency: got cyc=%0d early_dones=%0d expected 256 0", cyc, dones);
        end
        vectors++;
        if (prim !== 1'b1 || order !== 8'd255) begin
            miscompares++; $display("FAIL restart_order: got prim=%b order=%0d expected 1 255", prim, order);
        end
        lookup(8'd254, 8'h03);
        vectors++;
        if (exp_data !== 8'h8E || log_hit !== 1'b1 || log_data !== 8'd25) begin
            miscompares++;
            $display("FAIL restart_lookup: got exp=%h hit=%b log=%0d expected exp=8e hit=1 log=25", exp_data, log_hit, log_data);
        end
        lookup(8'd51, 8'h8E);
        vectors++;
        if (exp_data === 8'h01 || log_hit !== 1'b1 || log_data !== 8'd254) begin
            miscompares++;
            $display("FAIL restart_stale: got exp51=%h log8e hit=%b data=%0d expected exp51!=01 hit=1 data=254",
                     exp_data, log_hit, log_data);
        end
    endtask

    task automatic test_mid_build_reset();
        int dones;
        start = 1'b1; poly = 8'h1D;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        lookup(8'd5, 8'h02);
        vectors++;
        if (exp_vld !== 1'b1 || exp_data !== 8'h00 || log_vld !== 1'b1 || log_hit !== 1'b0 || log_data !== 8'h00) begin
            miscompares++;
            $display("FAIL busy_lookup: got exp=%b/%h log=%b/%b/%h expected 1/00 1/0/00",
                     exp_vld, exp_data, log_vld, log_hit, log_data);
        end
        repeat (39) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL midrst_pre_busy: got %b expected 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || ready !== 1'b0 || order !== 8'h00) begin
            miscompares++;
            $display("FAIL midrst_async: got busy=%b ready=%b order=%h expected 0 0 00", busy, ready, order);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones !== 0 || busy !== 1'b0 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_no_done: got dones=%0d busy=%b ready=%b expected 0 0 0", dones, busy, ready);
        end
    endtask

    initial begin
        test_reset();
        test_primitive();
        test_nonprimitive();
        test_edges();
        test_back_to_back();
        test_bad_poly();
        test_restart();
        test_mid_build_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
